// File: rtl/regfile_write_queue.sv
// regfile_write_queue
// Write-side front end for the 4x8 dual-port register file. Accepted writes
// sit in a small in-order queue and are drained one at a time with a
// setup / strobe / hold sequence on the active-low, latch-type write enable.
// Both read ports are forwarded from the queue so a pending write is never
// hidden behind a stale register-file value.
//
// Drain FSM
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | queue empty, wr_en_n high
//   S_SETUP  | address/data driven to the file, wr_en_n high
//   S_STROBE | wr_en_n low for exactly one cycle
//   S_HOLD   | wr_en_n high, address/data held; head pops at the end

module regfile_write_queue #(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_addr,
    input  logic [7:0]              in_data,
    output logic                    wr_en_n,
    output logic [1:0]              wr_addr,
    output logic [7:0]              wr_data,
    input  logic [1:0]              rdL_addr,
    input  logic [7:0]              rdL_file,
    output logic [7:0]              rdL_data,
    output logic                    rdL_fwd,
    input  logic [1:0]              rdR_addr,
    input  logic [7:0]              rdR_file,
    output logic [7:0]              rdR_data,
    output logic                    rdR_fwd,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mem_addr_q [DEPTH];
    logic [7:0]      mem_data_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q, head_nxt;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en_n_q, wr_en_n_d;
    logic [1:0]      wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            push, pop;
    logic [PW-1:0]   idx_l, idx_r;

    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head_nxt = head_q + PW'(1);

    assign wr_en_n = wr_en_n_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign count   = count_q;
    assign busy    = (count_q != '0) || (state_q != S_IDLE);

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_addr_q[tail_q] <= in_addr;
                mem_data_q[tail_q] <= in_data;
                tail_q             <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_nxt;
            end
            count_q <= count_d;
        end
    end

    // Drain FSM next state. When the queue is empty at the decision point but a
    // write is being accepted on that same edge, the new entry is loaded straight
    // from the input so the write still gets a full SETUP without an idle cycle.
    always_comb begin
        state_d   = state_q;
        wr_en_n_d = 1'b1;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d   = S_SETUP;
                    wr_addr_d = mem_addr_q[head_q];
                    wr_data_d = mem_data_q[head_q];
                end else if (push) begin
                    state_d   = S_SETUP;
                    wr_addr_d = in_addr;
                    wr_data_d = in_data;
                end
            end
            S_SETUP: begin
                state_d   = S_STROBE;
                wr_en_n_d = 1'b0;
            end
            S_STROBE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                pop = 1'b1;
                if (count_q > CW'(1)) begin
                    state_d   = S_SETUP;
                    wr_addr_d = mem_addr_q[head_nxt];
                    wr_data_d = mem_data_q[head_nxt];
                end else if (push) begin
                    state_d   = S_SETUP;
                    wr_addr_d = in_addr;
                    wr_data_d = in_data;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Drain FSM state and registered register-file drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_en_n_q <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_n_q <= wr_en_n_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Left port forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        rdL_data = rdL_file;
        rdL_fwd  = 1'b0;
        idx_l    = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx_l = head_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_addr_q[idx_l] == rdL_addr)) begin
                rdL_data = mem_data_q[idx_l];
                rdL_fwd  = 1'b1;
            end
        end
    end

    // Right port forwarding, identical to the left port.
    always_comb begin
        rdR_data = rdR_file;
        rdR_fwd  = 1'b0;
        idx_r    = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx_r = head_q + PW'(i);
            if ((CW'(i) < count_q) && (mem_addr_q[idx_r] == rdR_addr)) begin
                rdR_data = mem_data_q[idx_r];
                rdR_fwd  = 1'b1;
            end
        end
    end

endmodule
